// File: rtl/ar32_pkg.sv
// Shared widths and FSM encoding for the shared 32x32 multiplier scheduler.
package ar32_pkg;
  localparam int A_W = 32;
  localparam int K_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/ar32_mul_sched_ar32.sv
// AR_32: combinational unsigned 32x32 array multiplier (deep ripple, timed as a multicycle path).
module AR_32
  import ar32_pkg::*;
(
  input  logic [A_W-1:0] a,
  input  logic [A_W-1:0] b,
  output logic [K_W-1:0] k
);
  logic [K_W-1:0] acc_s;

  // Accumulate one shifted partial product per bit of b.
  always_comb begin
    acc_s = '0;
    for (int i = 0; i < A_W; i++) begin
      if (b[i]) begin
        acc_s = acc_s + (K_W'(a) << i);
      end else begin
        acc_s = acc_s;
      end
    end
  end

  assign k = acc_s;
endmodule

// File: rtl/ar32_mul_sched_rr_pick.sv
// rr_pick: first set request at or after ptr, searching upward modulo NREQ.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  localparam int SW = IDW + 1;

  logic [2*NREQ-1:0] rot_s;
  logic [IDW-1:0]    off_s;
  logic [SW-1:0]     sum_s;
  logic [IDW-1:0]    idx_s;
  logic              any_s;

  // Rotate so ptr sits at bit 0, then take the lowest set bit as the offset.
  always_comb begin
    rot_s = {req, req} >> ptr;
    off_s = '0;
    any_s = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        any_s = 1'b1;
        off_s = IDW'(i);
      end else begin
        any_s = any_s;
      end
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= SW'(NREQ)) begin
      idx_s = IDW'(sum_s - SW'(NREQ));
    end else begin
      idx_s = sum_s[IDW-1:0];
    end
  end

  // One-hot grant derived from the chosen index.
  always_comb begin
    if (any_s) begin
      grant = NREQ'(1) << idx_s;
    end else begin
      grant = '0;
    end
  end

  assign idx = idx_s;
  assign any = any_s;
endmodule

// File: rtl/ar32_mul_sched.sv
// Round-robin scheduler sharing one AR_32 multiplier; operands held MUL_CYCLES cycles before sampling.
module ar32_mul_sched
  import ar32_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int MUL_CYCLES = 4,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_a,
  input  logic [NREQ*32-1:0]  req_b,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [63:0]         resp_k,
  output logic                busy
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int PW = IDW + 1;

  state_t          state_r, state_nxt_s;
  logic [IDW-1:0]  rr_ptr_r, id_r, resp_id_r, gidx_s, ptr_inc_s;
  logic [NREQ-1:0] grant_s, req_ready_s;
  logic            any_s;
  logic [A_W-1:0]  op_a_r, op_b_r, sel_a_s, sel_b_s;
  logic [K_W-1:0]  prod_s, resp_k_r;
  logic [CW-1:0]   cnt_r;
  logic [PW-1:0]   ptr_sum_s;
  logic            resp_valid_r, busy_r;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .idx   (gidx_s),
    .any   (any_s)
  );

  // Operands are only ever taken from op_a_r/op_b_r, which stay frozen through CALC.
  AR_32 u_mul (
    .a (op_a_r),
    .b (op_b_r),
    .k (prod_s)
  );

  // Select the granted requester's operand slices.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gidx_s == IDW'(r)) begin
        sel_a_s = req_a[r*A_W +: A_W];
        sel_b_s = req_b[r*A_W +: A_W];
      end else begin
        sel_a_s = sel_a_s;
        sel_b_s = sel_b_s;
      end
    end
  end

  // Pointer moves just past the requester whose response was accepted.
  always_comb begin
    ptr_sum_s = {1'b0, resp_id_r} + PW'(1);
    if (ptr_sum_s == PW'(NREQ)) begin
      ptr_inc_s = '0;
    end else begin
      ptr_inc_s = ptr_sum_s[IDW-1:0];
    end
  end

  // Next-state and grant decode.
  always_comb begin
    state_nxt_s = state_r;
    req_ready_s = '0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          req_ready_s = grant_s;
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CW'(0)) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = CALC;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand, counter, pointer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r     <= '0;
      op_a_r       <= '0;
      op_b_r       <= '0;
      id_r         <= '0;
      cnt_r        <= '0;
      resp_valid_r <= 1'b0;
      resp_k_r     <= '0;
      resp_id_r    <= '0;
      busy_r       <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (any_s) begin
            op_a_r <= sel_a_s;
            op_b_r <= sel_b_s;
            id_r   <= gidx_s;
            cnt_r  <= CW'(MUL_CYCLES - 1);
          end
        end
        CALC: begin
          if (cnt_r != CW'(0)) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            resp_k_r     <= prod_s;
            resp_id_r    <= id_r;
            resp_valid_r <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            rr_ptr_r     <= ptr_inc_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Grant is combinational; masked while reset is asserted so it reads 0 in reset.
  assign req_ready  = req_ready_s & {NREQ{rst_n}};
  assign resp_valid = resp_valid_r;
  assign resp_k     = resp_k_r;
  assign resp_id    = resp_id_r;
  assign busy       = busy_r;
endmodule

// File: tb/tb_ar32_mul_sched.sv
// Scoreboard bench for ar32_mul_sched: NREQ=4 with MUL_CYCLES=4, plus a MUL_CYCLES=1 instance.
module tb_ar32_mul_sched;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic         resp_valid, resp_ready, busy;
  logic [1:0]   resp_id;
  logic [63:0]  resp_k;

  logic [3:0]   req_valid1, req_ready1;
  logic [127:0] req_a1, req_b1;
  logic         resp_valid1, resp_ready1, busy1;
  logic [1:0]   resp_id1;
  logic [63:0]  resp_k1;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] k;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          grant_log[$];
  int          grant_cyc[$];
  logic [63:0] k_log[$];
  logic [1:0]  last_id;
  int          errors = 0, checks = 0, cyc = 0, rise_cyc = 0, resp_cnt = 0;
  logic        prev_v = 1'b0, auto_drop = 1'b0;

  always #5 clk = ~clk;

  ar32_mul_sched #(.NREQ(4), .MUL_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_k(resp_k), .busy(busy)
  );

  ar32_mul_sched #(.NREQ(4), .MUL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_id(resp_id1), .resp_k(resp_k1), .busy(busy1)
  );

  // One clock: observe grants/responses at negedge, advance to just after the next posedge.
  task automatic tick();
    logic [3:0] g;
    exp_t e;
    int gi;
    @(negedge clk);
    g = req_valid & req_ready;
    if (g != 4'd0) begin
      gi = 0;
      for (int i = 0; i < 4; i++) if (g[i]) gi = i;
      checks++;
      if ($countones(req_ready) != 1) begin
        errors++; $display("FAIL grant_onehot: req_ready=%b", req_ready);
      end
      e.id  = 2'(gi);
      e.k   = 64'(req_a[gi*32 +: 32]) * 64'(req_b[gi*32 +: 32]);
      e.acc = cyc;
      sbq.push_back(e);
      grant_log.push_back(gi);
      grant_cyc.push_back(cyc);
    end
    if (resp_valid && !prev_v) rise_cyc = cyc;
    prev_v = resp_valid;
    if (resp_valid && resp_ready) begin
      resp_cnt++;
      k_log.push_back(resp_k);
      last_id = resp_id;
      checks++;
      if (sbq.size() == 0) begin
        errors++; $display("FAIL sb_unexpected: resp_k=%h resp_id=%0d with nothing expected", resp_k, resp_id);
      end else begin
        e = sbq.pop_front();
        checks += 3;
        if (resp_k !== e.k) begin
          errors++; $display("FAIL sb_k: got %h expected %h", resp_k, e.k);
        end
        if (resp_id !== e.id) begin
          errors++; $display("FAIL sb_id: got %0d expected %0d", resp_id, e.id);
        end
        if (rise_cyc - e.acc != 5) begin
          errors++; $display("FAIL sb_latency: got %0d expected 5", rise_cyc - e.acc);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (auto_drop) req_valid = req_valid & ~g;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (req_ready !== 4'd0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
    if (resp_k !== 64'd0) begin errors++; $display("FAIL reset_resp_k: got %h expected 0", resp_k); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (resp_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_dut1: resp_valid=%b busy=%b expected 0 0", resp_valid1, busy1);
    end
    req_valid = 4'd0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int base, n;
    resp_ready = 1'b1; auto_drop = 1'b1;
    req_a[95:64] = 32'hFFFF_FFFF; req_b[95:64] = 32'hFFFF_FFFF;
    req_valid = 4'b0100;
    base = resp_cnt; n = 0;
    while (resp_cnt == base && n < 40) begin tick(); n++; end
    checks++;
    if (resp_cnt == base) begin
      errors++; $display("FAIL single_timeout: no response within %0d cycles", n);
    end else begin
      checks += 3;
      if (k_log[$] !== 64'hFFFF_FFFE_0000_0001) begin
        errors++; $display("FAIL single_k: got %h expected fffffffe00000001", k_log[$]);
      end
      if (last_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", last_id); end
      if (rise_cyc - grant_cyc[$] != 5) begin
        errors++; $display("FAIL single_latency: got %0d expected 5", rise_cyc - grant_cyc[$]);
      end
    end
  endtask

  task automatic test_wrap_edge_operands();
    int base, gb, n;
    auto_drop = 1'b1;
    req_a[31:0]   = 32'h0000_0001; req_b[31:0]   = 32'h8000_0000;
    req_a[127:96] = 32'h0000_0000; req_b[127:96] = 32'h1234_5678;
    req_valid = 4'b1001;
    base = resp_cnt; gb = grant_log.size(); n = 0;
    while (resp_cnt < base + 2 && n < 60) begin tick(); n++; end
    checks++;
    if (resp_cnt < base + 2) begin
      errors++; $display("FAIL wrap_timeout: %0d of 2 responses", resp_cnt - base);
    end else begin
      checks += 4;
      if (grant_log[gb] != 3) begin errors++; $display("FAIL wrap_first: got r%0d expected r3", grant_log[gb]); end
      if (grant_log[gb+1] != 0) begin errors++; $display("FAIL wrap_second: got r%0d expected r0", grant_log[gb+1]); end
      if (k_log[base] !== 64'd0) begin errors++; $display("FAIL edge_zero: got %h expected 0", k_log[base]); end
      if (k_log[base+1] !== 64'h0000_0000_8000_0000) begin
        errors++; $display("FAIL edge_msb: got %h expected 0000000080000000", k_log[base+1]);
      end
    end
  endtask

  task automatic test_round_robin();
    int gb, n;
    rst_n = 1'b0; #1; sbq.delete(); prev_v = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      req_a[r*32 +: 32] = 32'(2*r + 1);
      req_b[r*32 +: 32] = 32'(r + 4);
    end
    auto_drop = 1'b0; resp_ready = 1'b1;
    req_valid = 4'hF;
    gb = grant_log.size(); n = 0;
    while (grant_log.size() < gb + 5 && n < 100) begin tick(); n++; end
    req_valid = 4'd0;
    checks++;
    if (grant_log.size() < gb + 5) begin
      errors++; $display("FAIL rr_timeout: %0d of 5 grants", grant_log.size() - gb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_log[gb+i] != (i % 4)) begin
          errors++; $display("FAIL rr_order[%0d]: got r%0d expected r%0d", i, grant_log[gb+i], i % 4);
        end
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (grant_cyc[gb+i] - grant_cyc[gb+i-1] != 6) begin
          errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 6", i, grant_cyc[gb+i] - grant_cyc[gb+i-1]);
        end
      end
    end
    n = 0;
    while (sbq.size() != 0 && n < 40) begin tick(); n++; end
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL rr_drain: %0d responses missing", sbq.size()); end
  endtask

  task automatic test_backpressure();
    logic [63:0] k0;
    logic [1:0]  id0;
    int n, base;
    resp_ready = 1'b0; auto_drop = 1'b1;
    req_a[63:32] = 32'h0001_0000; req_b[63:32] = 32'h0001_0000;
    req_a[95:64] = 32'h0000_0007; req_b[95:64] = 32'h0000_000B;
    req_valid = 4'b0110;
    n = 0;
    while (!resp_valid && n < 20) begin tick(); n++; end
    checks++;
    if (!resp_valid) begin
      errors++; $display("FAIL bp_timeout: resp_valid=0 expected 1");
    end else begin
      k0 = resp_k; id0 = resp_id;
      checks += 2;
      if (k0 !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL bp_k: got %h expected 0000000100000000", k0); end
      if (id0 !== 2'd1) begin errors++; $display("FAIL bp_id: got %0d expected 1", id0); end
      for (int i = 0; i < 10; i++) begin
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_k !== k0 || resp_id !== id0 || req_ready !== 4'd0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL bp_hold[%0d]: valid=%b k=%h id=%0d req_ready=%b busy=%b expected 1 %h %0d 0000 1",
                   i, resp_valid, resp_k, resp_id, req_ready, busy, k0, id0);
        end
      end
      base = resp_cnt;
      resp_ready = 1'b1;
      tick();
      checks += 2;
      if (resp_cnt != base + 1) begin errors++; $display("FAIL bp_release: got %0d handshakes expected 1", resp_cnt - base); end
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", resp_valid); end
    end
    n = 0;
    while ((sbq.size() != 0 || req_valid != 4'd0) && n < 40) begin tick(); n++; end
    checks++;
    if (sbq.size() != 0 || req_valid != 4'd0) begin
      errors++; $display("FAIL bp_drain: pending=%0d req_valid=%b expected 0 0", sbq.size(), req_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    int gb, n, rbase;
    resp_ready = 1'b1; auto_drop = 1'b1;
    req_a[127:96] = 32'h0000_0005; req_b[127:96] = 32'h0000_0006;
    req_valid = 4'b1000;
    gb = grant_log.size(); n = 0;
    while (grant_log.size() == gb && n < 20) begin tick(); n++; end
    tick(); tick();
    rst_n = 1'b0;
    req_valid = 4'b1001;
    #1;
    checks += 2;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 4'd0) begin
      errors++; $display("FAIL mid_reset_ctrl: busy=%b resp_valid=%b req_ready=%b expected 0 0 0", busy, resp_valid, req_ready);
    end
    if (resp_k !== 64'd0 || resp_id !== 2'd0) begin
      errors++; $display("FAIL mid_reset_data: resp_k=%h resp_id=%0d expected 0 0", resp_k, resp_id);
    end
    sbq.delete(); prev_v = 1'b0;
    req_valid = 4'd0;
    tick();
    rst_n = 1'b1;
    rbase = resp_cnt;
    repeat (8) tick();
    checks++;
    if (resp_cnt != rbase || resp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_discard: %0d responses, resp_valid=%b expected 0 0", resp_cnt - rbase, resp_valid);
    end
    req_a[31:0] = 32'h0000_0009; req_b[31:0] = 32'h0000_0003;
    req_valid = 4'b1001;
    gb = grant_log.size(); n = 0;
    while (sbq.size() == 0 && n < 20) begin tick(); n++; end
    checks++;
    if (grant_log.size() == gb || grant_log[gb] != 0) begin
      errors++; $display("FAIL mid_reset_ptr: got first grant %0d expected r0", (grant_log.size() == gb) ? -1 : grant_log[gb]);
    end
    n = 0;
    while ((sbq.size() != 0 || req_valid != 4'd0) && n < 40) begin tick(); n++; end
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL mid_reset_drain: %0d responses missing", sbq.size()); end
  endtask

  task automatic test_mc1();
    int n;
    resp_ready1 = 1'b1;
    req_a1[31:0] = 32'h0000_0007; req_b1[31:0] = 32'h0000_0009;
    req_valid1 = 4'b0001;
    #1;
    checks++;
    if (req_ready1 !== 4'b0001) begin errors++; $display("FAIL mc1_grant: got %b expected 0001", req_ready1); end
    tick();
    req_valid1 = 4'd0;
    n = 1;
    while (!resp_valid1 && n < 20) begin tick(); n++; end
    checks += 3;
    if (n != 2) begin errors++; $display("FAIL mc1_latency: got %0d expected 2", n); end
    if (resp_k1 !== 64'd63) begin errors++; $display("FAIL mc1_k: got %h expected 3f", resp_k1); end
    if (resp_id1 !== 2'd0) begin errors++; $display("FAIL mc1_id: got %0d expected 0", resp_id1); end
    tick();
    checks++;
    if (resp_valid1 !== 1'b0) begin errors++; $display("FAIL mc1_handshake: resp_valid=%b expected 0", resp_valid1); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'd0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    req_valid1 = 4'd0; req_a1 = '0; req_b1 = '0; resp_ready1 = 1'b0;
    last_id = 2'd0;
    test_reset();
    test_single();
    test_wrap_edge_operands();
    test_round_robin();
    test_backpressure();
    test_reset_mid_calc();
    test_mc1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
